// File: rtl/receive_fsm_pkg.sv
// Shared definitions for the serial receive path.
// State encoding and default baud constant, common with the transmit FSM.
package receive_fsm_pkg;

  localparam int DEFAULT_CLKS_PER_BIT = 868;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    STOP    = 3'd3,
    RECOVER = 3'd4
  } rx_state_t;

endpackage

// File: rtl/receive_fsm_sync_2ff.sv
// Parameterised-width two-flop synchroniser.
// Async active-high reset to a configurable value.
module sync_2ff #(
  parameter int           W       = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_meta;
  logic [W-1:0] r_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/receive_fsm.sv
// Serial receiver: 1 start, DATA_BITS data LSB first, 1 stop.
// Emits a one-cycle valid or framing-error strobe per frame.
module receive_fsm
  import receive_fsm_pkg::*;
#(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int IDX_W = $clog2(DATA_BITS + 1);

  localparam logic [CNT_W-1:0] HALF_CNT =
    CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] LAST_CNT =
    CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX =
    IDX_W'(DATA_BITS - 1);

  logic                 w_rx_s;
  rx_state_t            r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [IDX_W-1:0]     r_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] r_data_out;
  logic                 r_valid;
  logic                 r_ferr;

  sync_2ff #(
    .W       (1),
    .RST_VAL (1'b1)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .i_d (rx),
    .o_q (w_rx_s)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_shift    <= '0;
      r_data_out <= '0;
      r_valid    <= 1'b0;
      r_ferr     <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      unique case (r_state)
        IDLE: begin
          r_cnt <= '0;
          if (!w_rx_s) r_state <= START;
        end
        START: begin
          if (r_cnt == HALF_CNT) begin
            r_cnt <= '0;
            r_idx <= '0;
            // A high line at mid start bit is a glitch
            r_state <= w_rx_s ? IDLE : DATA;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DATA: begin
          if (r_cnt == LAST_CNT) begin
            r_cnt   <= '0;
            r_shift <= {w_rx_s, r_shift[DATA_BITS-1:1]};
            r_idx   <= r_idx + 1'b1;
            if (r_idx == LAST_IDX) r_state <= STOP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        STOP: begin
          if (r_cnt == LAST_CNT) begin
            r_cnt <= '0;
            if (w_rx_s) begin
              r_data_out <= r_shift;
              r_valid    <= 1'b1;
              r_state    <= IDLE;
            end else begin
              r_ferr  <= 1'b1;
              r_state <= RECOVER;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RECOVER: begin
          // Wait out a break so it is not seen as new starts
          r_cnt <= '0;
          if (w_rx_s) r_state <= IDLE;
        end
        default: begin
          r_cnt   <= '0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign data_out   = r_data_out;
  assign data_valid = r_valid;
  assign frame_err  = r_ferr;
  assign busy       = (r_state != IDLE);

endmodule

// File: doc/receive_fsm.md
Name: receive_fsm

Overview:
- Serial receive state machine; the receive-side counterpart of the team's transmit FSM.
- Deserialises an asynchronous, idle-high serial line: 1 start bit (0), DATA_BITS data bits LSB first, 1 stop bit (1).
- Presents each completed word on a parallel bus with a one-cycle valid strobe. Flags framing errors.
- Sits between the board RX pin and the downstream command/data consumer.

Parameters:
- DATA_BITS, 8, number of data bits per frame.
- CLKS_PER_BIT, 868, clk cycles per bit period (100 MHz / 115200 baud); must be ≥ 4.
- CNT_W, $clog2(CLKS_PER_BIT), width of the bit-period counter (derived; do not override).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- rx  input  1  raw serial line, asynchronous to clk, idle high.
- data_out  output  DATA_BITS  last correctly framed word; holds until the next good frame.
- data_valid  output  1  one-cycle pulse when data_out updates.
- frame_err  output  1  one-cycle pulse when the stop bit samples 0.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; counter=0; bit_idx=0; shift register=0.
  - data_out=0; data_valid=0; frame_err=0; busy=0.
  - Synchroniser flops=1.
  - Reset mid-frame discards the partial word with no strobe.
- Input path: rx passes through a 2-flop synchroniser to give rx_s. All decisions use rx_s only.
- States: IDLE, START, DATA, STOP, RECOVER (encoding in shared package).
- IDLE: when rx_s==0, go to START with counter=0.
- START:
  - Count to CLKS_PER_BIT/2 - 1 (mid start bit).
  - At that count: if rx_s==0, go to DATA with counter=0 and bit_idx=0. Otherwise treat as a glitch and return to IDLE with no strobe.
- DATA:
  - Count to CLKS_PER_BIT-1, then sample rx_s into the shift register MSB and shift right (LSB first on the line).
  - Increment bit_idx and reset counter.
  - After sampling bit DATA_BITS-1, go to STOP.
- STOP: count to CLKS_PER_BIT-1, then sample rx_s.
  - rx_s==1: data_out <= shift register; data_valid=1 for exactly that cycle; go to IDLE.
  - rx_s==0: frame_err=1 for exactly that cycle; data_out unchanged; go to RECOVER.
- RECOVER: stay until rx_s==1, then go to IDLE. This prevents a break condition (line held low) from being read as repeated start bits.
- Latency: data_valid rises 2 + CLKS_PER_BIT/2 + (DATA_BITS+1)·CLKS_PER_BIT cycles (±1 for the transition decision) after the rx falling edge of the start bit.
- Strobe exclusivity: data_valid and frame_err are never high in the same cycle. Both are registered outputs.
- Back-to-back frames: a start bit immediately following the stop sample is detected with no lost frame. IDLE is re-entered before the next falling edge reaches mid-bit.
- Counter: CNT_W bits, resets to 0 on every state transition, never wraps within a state.
- bit_idx: $clog2(DATA_BITS+1) bits.

Decomposition:
- Shared package/include: state encodings (IDLE, START, DATA, STOP, RECOVER) and the default baud constant.
  - The transmit FSM uses the same default baud constant, so both ends agree.
- Sub-module: sync_2ff, a parameterised-width 2-flop synchroniser. Async active-high reset; reset value parameter set to 1 here.
- Everything else lives in receive_fsm.

Test Plan (CLKS_PER_BIT=16, DATA_BITS=8):
- Reset then idle: rx=1 for 500 cycles -> data_valid, frame_err and busy stay 0; data_out=0x00.
- Single frame 0xA5 (LSB first, good stop) -> exactly one data_valid pulse; data_out=0xA5; valid at 2+8+9·16 ±1 cycles after start edge.
- Glitch: rx low for 4 cycles then high -> START aborts to IDLE; no strobes; busy returns to 0 within 10 cycles.
- Bad stop: frame 0x3C with stop bit 0 and rx then held low 100 cycles -> one frame_err pulse; data_out keeps its previous value; state stays RECOVER until rx=1; no further strobes.
- Back-to-back frames 0x00, 0xFF, 0x55 with no idle gap -> three data_valid pulses, in that order, with those values.
- Reset asserted mid DATA of frame 0x81, then released, then frame 0x42 sent -> no strobe for 0x81; data_out=0x00 until the 0x42 frame ends, then 0x42.
